// File: rtl/shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_universal
// Brief    : WIDTH-bit universal register (hold / shift right / shift left /
//            parallel load) with a modulo-WIDTH shift counter and a
//            registered word-complete pulse for SERDES staging.
// Revision : 1.0 - initial release
// ============================================================================
module shift_register_universal #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         d,
    input  logic                     serial_in_r,
    input  logic                     serial_in_l,
    output logic [WIDTH-1:0]         q,
    output logic                     serial_out_r,
    output logic                     serial_out_l,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     word_done
);

    localparam int                 CNT_W        = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   c_CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE    = CNT_W'(1);
    localparam logic [1:0]         c_MODE_HOLD  = 2'b00;
    localparam logic [1:0]         c_MODE_RIGHT = 2'b01;
    localparam logic [1:0]         c_MODE_LEFT  = 2'b10;
    localparam logic [1:0]         c_MODE_LOAD  = 2'b11;

    // Power-up values match the reset values.
    logic [WIDTH-1:0] r_q    = RESET_VALUE;
    logic [CNT_W-1:0] r_cnt  = '0;
    logic             r_done = 1'b0;

    logic w_shift;
    logic w_load;
    logic w_wrap;

    // Decode which kind of update the counter sees this cycle.
    always_comb begin
        w_shift = enable && ((mode == c_MODE_RIGHT) || (mode == c_MODE_LEFT));
        w_load  = enable && (mode == c_MODE_LOAD);
        w_wrap  = (r_cnt == c_CNT_LAST);
    end

    // Data register: mode applied only while enabled, reset overrides all.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (enable) begin
            case (mode)
                c_MODE_HOLD:  r_q <= r_q;
                c_MODE_RIGHT: r_q <= {serial_in_r, r_q[WIDTH-1:1]};
                c_MODE_LEFT:  r_q <= {r_q[WIDTH-2:0], serial_in_l};
                c_MODE_LOAD:  r_q <= d;
                default:      r_q <= r_q;
            endcase
        end
    end

    // Shift counter and word-complete pulse; a load restarts the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (w_load) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (w_shift) begin
            if (w_wrap) begin
                r_cnt  <= '0;
                r_done <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + c_CNT_ONE;
                r_done <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign q            = r_q;
    assign serial_out_r = r_q[0];
    assign serial_out_l = r_q[WIDTH-1];
    assign bit_count    = r_cnt;
    assign word_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_register_universal
// Brief    : Scoreboard bench for shift_register_universal. A driver issues
//            stimulus and pushes the reference model's expected state; a
//            monitor pops one entry per clock and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register_universal;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] d = '0;
    logic         serial_in_r = 1'b0;
    logic         serial_in_l = 1'b0;

    logic [W-1:0] q_a, q_b;
    logic         sor_a, sol_a, sor_b, sol_b;
    logic [2:0]   cnt_a, cnt_b;
    logic         done_a, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int    qa;
        int    qb;
        int    cnt;
        bit    done;
        string tag;
    } exp_t;

    exp_t sb[$];

    // reference model state
    int  m_qa   = 0;
    int  m_qb   = 'hA5;
    int  m_cnt  = 0;
    bit  m_done = 0;

    shift_register_universal #(.WIDTH(W), .RESET_VALUE(8'h00)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .d(d),
        .serial_in_r(serial_in_r), .serial_in_l(serial_in_l),
        .q(q_a), .serial_out_r(sor_a), .serial_out_l(sol_a),
        .bit_count(cnt_a), .word_done(done_a)
    );

    shift_register_universal #(.WIDTH(W), .RESET_VALUE(8'hA5)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .d(d),
        .serial_in_r(serial_in_r), .serial_in_l(serial_in_l),
        .q(q_b), .serial_out_r(sor_b), .serial_out_l(sol_b),
        .bit_count(cnt_b), .word_done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [%s] @%0t: got %0h expected %0h", name, tag, $time, act, exp);
        end
    endtask

    // one model step from the rules: integer arithmetic on whole words
    function automatic int shr(input int v, input bit s);
        return (v >> 1) | (int'(s) << (W - 1));
    endfunction
    function automatic int shl(input int v, input bit s);
        return ((v << 1) | int'(s)) & ((1 << W) - 1);
    endfunction

    task automatic step(input bit rst, input bit en, input logic [1:0] md,
                        input logic [W-1:0] dd, input bit sr, input bit sl,
                        input string tag);
        exp_t e;
        @(negedge clk);
        reset = rst; enable = en; mode = md; d = dd;
        serial_in_r = sr; serial_in_l = sl;
        if (rst) begin
            m_qa = 0; m_qb = 'hA5; m_cnt = 0; m_done = 0;
        end else if (!en || md == 2'b00) begin
            m_done = 0;
        end else if (md == 2'b11) begin
            m_qa = int'(dd); m_qb = int'(dd); m_cnt = 0; m_done = 0;
        end else begin
            if (md == 2'b01) begin
                m_qa = shr(m_qa, sr); m_qb = shr(m_qb, sr);
            end else begin
                m_qa = shl(m_qa, sl); m_qb = shl(m_qb, sl);
            end
            m_done = (m_cnt + 1 == W);
            m_cnt  = (m_cnt + 1) % W;
        end
        e.qa = m_qa; e.qb = m_qb; e.cnt = m_cnt; e.done = m_done; e.tag = tag;
        sb.push_back(e);
    endtask

    // monitor: after every rising edge compare DUT with the oldest expectation
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q", e.tag, int'(q_a), e.qa);
            check("q_rv", e.tag, int'(q_b), e.qb);
            check("bit_count", e.tag, int'(cnt_a), e.cnt);
            check("bit_count_rv", e.tag, int'(cnt_b), e.cnt);
            check("word_done", e.tag, int'(done_a), int'(e.done));
            check("word_done_rv", e.tag, int'(done_b), int'(e.done));
            check("serial_out_r", e.tag, int'(sor_a), e.qa & 1);
            check("serial_out_l", e.tag, int'(sol_a), (e.qa >> (W - 1)) & 1);
            check("serial_out_r_rv", e.tag, int'(sor_b), e.qb & 1);
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w1;
        logic [7:0] w2;
        bit         b;

        step(1, 0, 2'b00, 8'h00, 0, 0, "init_reset");

        // random traffic then reset
        for (int i = 0; i < 20; i++)
            step(0, 1, 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom), "rand_pre");
        step(1, 1, 2'b11, 8'hFF, 1, 1, "t1_reset");

        // load, hold, then disabled shift-right
        step(0, 1, 2'b11, 8'h96, 0, 0, "t2_load");
        for (int i = 0; i < 3; i++) step(0, 1, 2'b00, 8'h00, 1, 1, "t2_hold");
        for (int i = 0; i < 3; i++) step(0, 0, 2'b01, 8'h00, 1, 1, "t2_disabled");

        // load 81, shift right eight zeros
        step(0, 1, 2'b11, 8'h81, 0, 0, "t3_load");
        for (int i = 0; i < 8; i++) step(0, 1, 2'b01, 8'h00, 0, 0, "t3_shr");
        step(0, 1, 2'b00, 8'h00, 0, 0, "t3_after");

        // two streamed words, MSB first, shifted left
        step(0, 1, 2'b11, 8'h00, 0, 0, "t4_load");
        w1 = 8'hC3; w2 = 8'h5A;
        for (int i = 7; i >= 0; i--) step(0, 1, 2'b10, 8'h00, 0, w1[i], "t4_word1");
        for (int i = 7; i >= 0; i--) step(0, 1, 2'b10, 8'h00, 0, w2[i], "t4_word2");
        step(0, 1, 2'b00, 8'h00, 0, 0, "t4_after");

        // load wins over wrap; reset mid-word
        step(0, 1, 2'b11, 8'h12, 0, 0, "t5_load");
        for (int i = 0; i < 7; i++) step(0, 1, 2'b01, 8'h00, 1, 0, "t5_shift");
        step(0, 1, 2'b11, 8'hFF, 0, 0, "t5_load_wins");
        step(0, 1, 2'b00, 8'h00, 0, 0, "t5_no_pulse");
        for (int i = 0; i < 7; i++) step(0, 1, 2'b10, 8'h00, 0, 1, "t5_shift2");
        step(1, 1, 2'b10, 8'h00, 0, 1, "t5_reset");
        step(0, 1, 2'b00, 8'h00, 0, 0, "t5_no_pulse2");

        // alternating directions from 3C
        step(0, 1, 2'b11, 8'h3C, 0, 0, "t6_load");
        for (int i = 0; i < 8; i++) begin
            b = 1'($urandom);
            step(0, 1, (i % 2 == 0) ? 2'b10 : 2'b01, 8'h00, b, ~b, "t6_alt");
        end
        step(0, 1, 2'b00, 8'h00, 0, 0, "t6_after");

        // long random run, occasional reset and disable
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom), "random");

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", "end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
